// File: rtl/cpuConfig.sv
// Shared CPU configuration types: PC operation codes and sequencer states.
package cpuConfig;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_BR   = 3'd2,
    PC_JMP  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5,
    PC_HALT = 3'd6
  } pcOp_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STEP   = 2'd1,
    HALTED = 2'd2
  } seqState_t;

endpackage

// File: rtl/step_pulse_sync.sv
// Push-button synchroniser and rising-edge detector: one pulse per press.
// All flops reset to 1 so a button held through reset never yields a step.
module step_pulse_sync (
  input  logic clk,
  input  logic nReset,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser followed by a one-cycle-delayed copy for edge detect
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-address generator: increment, relative branch, jump, call/return
// through a small hardware return stack, halt, and push-button single-step.
module pc_sequencer
  import cpuConfig::*;
#(
  parameter int N           = 8,
  parameter int P_SIZE      = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  pcOp_t             pcOp,
  input  logic              branchCond,
  input  logic [N-1:0]      target,
  input  logic              stepMode,
  input  logic              stepBtn,
  output logic [P_SIZE-1:0] addressOut,
  output logic              halted,
  output logic              stackError
);

  // Pointer needs one extra bit to represent the "full" count.
  localparam int               SPW      = $clog2(STACK_DEPTH) + 1;
  localparam logic [SPW-1:0]   FULL_CNT = SPW'(STACK_DEPTH);

  seqState_t         state_q, state_d;
  logic [P_SIZE-1:0] pc_q, pc_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic              err_q, err_d;
  logic              halted_q;
  logic [P_SIZE-1:0] stack_q [STACK_DEPTH];

  logic [P_SIZE-1:0] pc_inc;
  logic [P_SIZE-1:0] tgt_addr;
  logic [SPW-2:0]    push_idx;
  logic [SPW-2:0]    top_idx;
  logic              push_en;
  logic              step_pulse;
  logic              adv;
  logic              stack_full;
  logic              stack_empty;

  step_pulse_sync u_step_sync (
    .clk     (clk),
    .nReset  (nReset),
    .async_i (stepBtn),
    .pulse_o (step_pulse)
  );

  // Only the low P_SIZE bits of the operand address program memory.
  if (N > P_SIZE) begin : g_unused_target
    logic unused_target_bits;
    assign unused_target_bits = ^target[N-1:P_SIZE];
  end

  assign pc_inc      = pc_q + P_SIZE'(1);
  assign tgt_addr    = target[P_SIZE-1:0];
  assign stack_full  = (sp_q == FULL_CNT);
  assign stack_empty = (sp_q == '0);
  assign push_idx    = sp_q[SPW-2:0];
  // At full count the low bits wrap to zero, so minus one still lands on the top entry.
  assign top_idx     = sp_q[SPW-2:0] - (SPW-1)'(1);
  assign adv         = ((state_q == RUN) && !stepMode) ||
                       ((state_q == STEP) && stepMode && step_pulse);

  // Next-state: mode transitions, then the decoded PC operation on advance cycles
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;

    case (state_q)
      RUN:     if (stepMode)  state_d = STEP;
      STEP:    if (!stepMode) state_d = RUN;
      default: state_d = state_q;
    endcase

    if (adv) begin
      case (pcOp)
        PC_HOLD: pc_d = pc_q;
        PC_INC:  pc_d = pc_inc;
        // Modular add of the low bits is the same as adding the sign-extended offset.
        PC_BR:   pc_d = branchCond ? (pc_q + tgt_addr) : pc_inc;
        PC_JMP:  pc_d = tgt_addr;
        PC_CALL: begin
          if (!stack_full) begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
            pc_d    = tgt_addr;
          end else begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end
        end
        PC_RET: begin
          if (!stack_empty) begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - SPW'(1);
          end else begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end
        end
        PC_HALT: state_d = HALTED;
        default: pc_d = pc_inc;
      endcase
    end
  end

  // Sequencer state, PC, stack pointer and status flags
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      sp_q     <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      err_q    <= err_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // Return-stack storage; contents survive reset, only the pointer clears
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign addressOut = pc_q;
  assign halted     = halted_q;
  assign stackError = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_pc_sequencer;
  import cpuConfig::*;

  localparam int N           = 8;
  localparam int P_SIZE      = 5;
  localparam int STACK_DEPTH = 4;
  localparam int MOD         = 1 << P_SIZE;
  localparam int S_RUN       = 0;
  localparam int S_STEP      = 1;
  localparam int S_HALT      = 2;

  logic              clk = 1'b0;
  logic              nReset = 1'b0;
  pcOp_t             pcOp = PC_INC;
  logic              branchCond = 1'b0;
  logic [N-1:0]      target = '0;
  logic              stepMode = 1'b0;
  logic              stepBtn = 1'b0;
  logic [P_SIZE-1:0] addressOut;
  logic              halted;
  logic              stackError;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_pc;
  int m_state;
  int m_err;
  int m_stack[$];
  int m_pending[$];
  int m_last_btn;
  int edge_no = 0;

  pc_sequencer #(.N(N), .P_SIZE(P_SIZE), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .pcOp       (pcOp),
    .branchCond (branchCond),
    .target     (target),
    .stepMode   (stepMode),
    .stepBtn    (stepBtn),
    .addressOut (addressOut),
    .halted     (halted),
    .stackError (stackError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = 0;
    m_state    = S_RUN;
    m_err      = 0;
    m_last_btn = 1;
    m_stack.delete();
    m_pending.delete();
  endtask

  // One rising edge of the model, using the inputs present at that edge
  task automatic model_edge();
    bit pulse;
    bit adv;
    int off;
    if (!nReset) begin
      model_reset();
      edge_no++;
      return;
    end
    // A press first seen at edge k produces its step at edge k+2.
    pulse = 1'b0;
    while (m_pending.size() > 0 && m_pending[0] <= edge_no) begin
      if (m_pending[0] == edge_no) pulse = 1'b1;
      void'(m_pending.pop_front());
    end
    if (stepBtn && m_last_btn == 0) m_pending.push_back(edge_no + 2);
    m_last_btn = int'(stepBtn);

    adv = (m_state == S_RUN && !stepMode) || (m_state == S_STEP && stepMode && pulse);
    if (m_state == S_RUN && stepMode) m_state = S_STEP;
    else if (m_state == S_STEP && !stepMode) m_state = S_RUN;

    if (adv) begin
      case (int'(pcOp))
        0: ;
        2: begin
          if (branchCond) begin
            off = int'(target) % MOD;
            if (off >= MOD / 2) off -= MOD;
            m_pc = (m_pc + off + MOD) % MOD;
          end else m_pc = (m_pc + 1) % MOD;
        end
        3: m_pc = int'(target) % MOD;
        4: begin
          if (m_stack.size() < STACK_DEPTH) begin
            m_stack.push_back((m_pc + 1) % MOD);
            m_pc = int'(target) % MOD;
          end else begin
            m_pc  = (m_pc + 1) % MOD;
            m_err = 1;
          end
        end
        5: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc  = (m_pc + 1) % MOD;
            m_err = 1;
          end
        end
        6: m_state = S_HALT;
        default: m_pc = (m_pc + 1) % MOD;
      endcase
    end
    edge_no++;
  endtask

  task automatic compare_model();
    check("pc_model", 32'(addressOut), m_pc);
    check("halted_model", 32'(halted), (m_state == S_HALT) ? 1 : 0);
    check("stackerr_model", 32'(stackError), m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drive(input pcOp_t op, input logic c, input int t);
    pcOp       = op;
    branchCond = c;
    target     = N'(t);
  endtask

  // Reset asserted between edges, checked immediately, released at the next falling edge
  task automatic async_reset();
    #2;
    nReset = 1'b0;
    model_reset();
    #1;
    compare_model();
    @(negedge clk);
    nReset = 1'b1;
  endtask

  initial begin
    int r;
    int halt_cnt;
    logic [2:0] raw_op;

    // Reset state
    model_reset();
    drive(PC_INC, 1'b0, 0);
    tick();
    tick();
    check("rst_pc", 32'(addressOut), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_err", 32'(stackError), 0);
    @(negedge clk);
    nReset = 1'b1;

    // Free-running increment with wrap
    for (int i = 0; i < 33; i++) begin
      tick();
      check("inc_count", 32'(addressOut), (i + 1) % MOD);
    end
    check("inc_halted", 32'(halted), 0);

    // Relative branches
    drive(PC_JMP, 1'b0, 10); tick();
    drive(PC_BR, 1'b1, 8'hFD); tick();
    check("br_back", 32'(addressOut), 7);
    drive(PC_JMP, 1'b0, 10); tick();
    drive(PC_BR, 1'b0, 8'hFD); tick();
    check("br_not_taken", 32'(addressOut), 11);
    drive(PC_JMP, 1'b0, 30); tick();
    drive(PC_BR, 1'b1, 8'h03); tick();
    check("br_wrap", 32'(addressOut), 1);

    // Nested calls and returns
    drive(PC_JMP, 1'b0, 2); tick();
    drive(PC_CALL, 1'b0, 20); tick();
    drive(PC_CALL, 1'b0, 25); tick();
    drive(PC_CALL, 1'b0, 28); tick();
    drive(PC_CALL, 1'b0, 16); tick();
    check("call_depth4", 32'(addressOut), 16);
    drive(PC_INC, 1'b0, 0); tick();
    check("call_body", 32'(addressOut), 17);
    drive(PC_RET, 1'b0, 0); tick();
    check("ret1", 32'(addressOut), 29);
    tick();
    check("ret2", 32'(addressOut), 26);
    tick();
    check("ret3", 32'(addressOut), 21);
    tick();
    check("ret4", 32'(addressOut), 3);
    check("ret_noerr", 32'(stackError), 0);
    drive(PC_CALL, 1'b0, 20); tick();
    drive(PC_CALL, 1'b0, 25); tick();
    drive(PC_CALL, 1'b0, 28); tick();
    drive(PC_CALL, 1'b0, 16); tick();
    drive(PC_CALL, 1'b0, 5); tick();
    check("call_full_pc", 32'(addressOut), 17);
    check("call_full_err", 32'(stackError), 1);
    drive(PC_INC, 1'b0, 0); tick(); tick();
    check("err_sticky", 32'(stackError), 1);

    // Underflow and reset clearing the error
    async_reset();
    check("rst2_err", 32'(stackError), 0);
    check("rst2_pc", 32'(addressOut), 0);
    drive(PC_JMP, 1'b0, 6); tick();
    drive(PC_RET, 1'b0, 0); tick();
    check("ret_empty_pc", 32'(addressOut), 7);
    check("ret_empty_err", 32'(stackError), 1);
    async_reset();
    check("rst3_err", 32'(stackError), 0);
    check("rst3_pc", 32'(addressOut), 0);

    // Single-step mode
    drive(PC_JMP, 1'b0, 12); tick();
    drive(PC_INC, 1'b0, 0);
    stepMode = 1'b1;
    tick(); tick(); tick();
    check("step_frozen", 32'(addressOut), 12);
    stepBtn = 1'b1;
    tick();
    check("step_k", 32'(addressOut), 12);
    tick();
    check("step_k1", 32'(addressOut), 12);
    tick();
    check("step_k2", 32'(addressOut), 13);
    for (int i = 0; i < 17; i++) tick();
    check("step_held_once", 32'(addressOut), 13);
    stepBtn = 1'b0;
    tick(); tick(); tick();
    check("step_release", 32'(addressOut), 13);
    stepMode = 1'b0;
    tick();
    check("step_exit", 32'(addressOut), 13);
    tick();
    check("run_resume", 32'(addressOut), 14);

    // Halt, ignored button presses, reset out of halt
    drive(PC_JMP, 1'b0, 9); tick();
    drive(PC_HALT, 1'b0, 0); tick();
    check("halt_pc", 32'(addressOut), 9);
    check("halt_flag", 32'(halted), 1);
    drive(PC_INC, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      stepBtn = (i % 8) < 4;
      tick();
    end
    stepBtn = 1'b0;
    check("halt_hold_pc", 32'(addressOut), 9);
    check("halt_hold_flag", 32'(halted), 1);
    async_reset();
    check("halt_rst_pc", 32'(addressOut), 0);
    check("halt_rst_flag", 32'(halted), 0);
    tick();
    check("halt_rst_run", 32'(addressOut), 1);

    // Random traffic against the model
    halt_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)      drive(PC_INC, 1'b0, 0);
      else if (r < 45) drive(PC_BR, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      else if (r < 55) drive(PC_JMP, 1'b0, int'($urandom_range(0, 255)));
      else if (r < 70) drive(PC_CALL, 1'b0, int'($urandom_range(0, 255)));
      else if (r < 85) drive(PC_RET, 1'b0, 0);
      else if (r < 90) drive(PC_HOLD, 1'b0, 0);
      else if (r < 93) drive(PC_HALT, 1'b0, 0);
      else begin
        raw_op = 3'd7;
        drive(pcOp_t'(raw_op), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 99) < 5)  stepMode = ~stepMode;
      if ($urandom_range(0, 99) < 20) stepBtn  = ~stepBtn;
      tick();
      halt_cnt = (m_state == S_HALT) ? halt_cnt + 1 : 0;
      if (halt_cnt > 6 || $urandom_range(0, 199) == 0) begin
        async_reset();
        halt_cnt = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-address generator sitting directly upstream of programMemory; drives its addressIn and replaces the increment-only programCounter. Executes the per-instruction PC operation from the decoder: increment, conditional relative branch, absolute jump, call/return via a small hardware return stack, and halt. Also provides a demo single-step mode driven by a board push-button.

Parameters:
N, 8, data bus width; the target/offset operand width.
P_SIZE, 5, program memory address width.
STACK_DEPTH, 4, return-stack entries (power of two, >=2).

Ports:
clk  input  1  system clock, all state on rising edge
nReset  input  1  asynchronous active-low reset
pcOp  input  cpuConfig::pcOp_t  PC operation for the current instruction, from decoder
branchCond  input  1  branch-taken condition (ALU zero flag), used by PC_BR only
target  input  N  jump address / signed branch offset (instruction opS field)
stepMode  input  1  1 = single-step mode (demo switch)
stepBtn  input  1  asynchronous push-button, active-high
addressOut  output  P_SIZE  current PC, to programMemory.addressIn and displayPC
halted  output  1  high in HALTED state
stackError  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (nReset low, async): addressOut=0, stack pointer=0, state=RUN, halted=0, stackError=0, synchroniser/edge flops=1 (no spurious step after reset).
- States: RUN, STEP, HALTED.
- "adv" = (state==RUN && !stepMode) || (state==STEP && stepPulse). PC and stack change only on adv cycles.
- RUN: stepMode=1 -> STEP, no advance that cycle.
- STEP: stepMode=0 -> RUN, no advance that cycle.
- HALTED: left only by reset.
- On adv, next PC by pcOp; all arithmetic is mod 2^P_SIZE and wraps, e.g. 31+1 -> 0:
  - PC_HOLD: unchanged.
  - PC_INC: PC+1.
  - PC_BR: branchCond ? PC + sext(target[P_SIZE-1:0]) : PC+1. The offset is P_SIZE-bit two's complement; upper target bits are ignored.
  - PC_JMP: target[P_SIZE-1:0].
  - PC_CALL: if not full, push PC+1 and PC=target[P_SIZE-1:0]. If full: no push, PC+1, stackError=1.
  - PC_RET: if not empty, pop into PC. If empty: PC+1, stackError=1.
  - PC_HALT: PC unchanged, state -> HALTED, halted=1 from next cycle.
- Undefined pcOp encodings behave as PC_INC.
- Stack: LIFO of P_SIZE-bit entries; count 0..STACK_DEPTH; full when count==STACK_DEPTH. Entries are not cleared on reset; only the pointer resets.
- stepBtn path: 2-flop synchroniser, then edge register; stepPulse = sync2 & ~prev, exactly one cycle per press. A press held for many cycles yields one pulse. stepBtn first sampled high at edge k -> addressOut updates at edge k+2.
- stepPulse while in RUN or HALTED is discarded.
- Reset mid-operation (any state, any stack depth) returns to reset values immediately and asynchronously; deassertion is used synchronously via the existing reset synchroniser upstream.
- addressOut is registered; programMemory is combinational, so instruction and pcOp for address A are valid in the same cycle addressOut==A. PC latency is one cycle per instruction.

Decomposition:
- cpuConfig package gains pcOp_t (PC_HOLD, PC_INC, PC_BR, PC_JMP, PC_CALL, PC_RET, PC_HALT; 3 bits) and seqState_t (RUN, STEP, HALTED).
- One sub-module, step_pulse_sync: the synchroniser and edge detector. Ports: clk, nReset, async in, pulse out.
- The return stack stays inline.

Test Plan:
1. Reset, then pcOp=PC_INC for 33 cycles with stepMode=0 -> addressOut counts 0..31, 0, 1; halted=0.
2. At PC=10: PC_BR with target=8'hFD and branchCond=1 -> PC=7. Same with branchCond=0 -> PC=11. At PC=30: PC_BR with target=8'h03 -> PC=1 (wrap).
3. Nested calls from PC=2 (target 20, 25, 28, 16) then 4x PC_RET -> PCs 17, 29, 26, 21, 3; stackError=0. A 5th CALL with stack full -> PC+1, stackError=1 and it stays 1.
4. PC_RET with empty stack at PC=6 -> PC=7, stackError=1. Assert nReset -> stackError=0, PC=0.
5. stepMode=1: PC frozen. One stepBtn press held 20 cycles -> exactly one PC advance, 2 edges after first sample. stepMode=0 -> free-run resumes the following cycle.
6. PC_HALT at PC=9 -> PC stays 9, halted=1, stepBtn presses ignored. nReset pulse mid-halt -> PC=0, RUN.
